spi_reg_frame_decoder: RTL and testbench

// - SPI-clock-domain register-access framer, running beside the byte-level SPI peripheral on the same MOSI/CS_n pins.
// - Parses framed commands straight off MOSI: byte0 = {R/nW, addr[6:0]}; then write data bytes or read data bytes.
// - Drives write requests to, and takes read data from, the target register bank.
// - Serializes read data onto a MISO bit that the top level muxes and tri-states.

---
 rtl/spi_reg_frame_decoder_if.sv | 27 ++
 rtl/spi_reg_frame_decoder.sv | 162 ++++++++++++++++
 tb/tb_spi_reg_frame_decoder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_frame_decoder_if.sv
// Register-bank side of the SPI frame decoder: write strobe/address/data out,
// read address out and read data back.
interface spi_reg_frame_decoder_if #(
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  o_Wr_Toggle;
  logic [ADDR_WIDTH-1:0] o_Wr_Addr;
  logic [7:0]            o_Wr_Data;
  logic [ADDR_WIDTH-1:0] o_Rd_Addr;
  logic [7:0]            i_Rd_Data;

  modport master (
    output o_Wr_Toggle,
    output o_Wr_Addr,
    output o_Wr_Data,
    output o_Rd_Addr,
    input  i_Rd_Data
  );

  modport slave (
    input  o_Wr_Toggle,
    input  o_Wr_Addr,
    input  o_Wr_Data,
    input  o_Rd_Addr,
    output i_Rd_Data
  );
endinterface

// File: rtl/spi_reg_frame_decoder.sv
// SPI-clock-domain register-access framer: decodes {R/nW, addr} command frames
// off MOSI, issues toggle-strobed writes and serialises read data onto MISO.
module spi_reg_frame_decoder #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned AUTO_INC   = 1
) (
  input  logic                   w_SPI_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_SPI_CS_n,
  input  logic                   i_SPI_MOSI,
  output logic                   o_SPI_MISO_Bit,
  output logic                   o_Frame_Err,
  spi_reg_frame_decoder_if.master reg_if
);

  localparam int unsigned    AW        = ADDR_WIDTH;
  localparam logic [AW-1:0]  ADDR_STEP = (AUTO_INC != 0) ? AW'(1) : AW'(0);

  typedef enum logic [1:0] {
    ST_CMD     = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_RD_TURN = 2'd2,
    ST_RD_DATA = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          frame_active_q;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  // Only 7 bits are stored: the 8th bit of a byte is MOSI itself at the byte edge.
  logic [6:0]    shift_q, shift_d;
  logic [6:0]    tx_q, tx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          miso_q, miso_d;
  logic          wr_toggle_q, wr_toggle_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          frame_err_q, frame_err_d;

  logic          first_edge_c;
  logic          byte_edge_c;
  logic [7:0]    rx_byte_c;

  assign first_edge_c = ~frame_active_q;
  assign byte_edge_c  = frame_active_q & (bit_cnt_q == 3'd7);
  assign rx_byte_c    = {shift_q, i_SPI_MOSI};

  // Frame marker: cleared asynchronously while CS_n is high.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
    if (!i_Rst_L) begin
      frame_active_q <= 1'b0;
    end else if (i_SPI_CS_n) begin
      frame_active_q <= 1'b0;
    end else begin
      frame_active_q <= 1'b1;
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_CMD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (first_edge_c) begin
      state_d = ST_CMD;
    end else if (byte_edge_c) begin
      case (state_q)
        ST_CMD:     state_d = rx_byte_c[7] ? ST_RD_TURN : ST_WR_DATA;
        ST_WR_DATA: state_d = ST_WR_DATA;
        ST_RD_TURN: state_d = ST_RD_DATA;
        ST_RD_DATA: state_d = ST_RD_DATA;
        default:    state_d = ST_CMD;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q + 3'd1;
    shift_d     = {shift_q[5:0], i_SPI_MOSI};
    tx_d        = tx_q;
    addr_d      = addr_q;
    miso_d      = 1'b0;
    wr_toggle_d = wr_toggle_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    frame_err_d = frame_err_q;
    if (first_edge_c) begin
      // A leftover bit count means the previous frame was cut mid-byte.
      bit_cnt_d = 3'd1;
      shift_d   = {6'd0, i_SPI_MOSI};
      if (bit_cnt_q != 3'd0) begin
        frame_err_d = 1'b1;
      end
    end else if (byte_edge_c) begin
      case (state_q)
        ST_CMD: begin
          if (rx_byte_c[7]) begin
            rd_addr_d = rx_byte_c[AW-1:0];
          end else begin
            addr_d = rx_byte_c[AW-1:0];
          end
        end
        ST_WR_DATA: begin
          wr_data_d   = rx_byte_c;
          wr_addr_d   = addr_q;
          wr_toggle_d = ~wr_toggle_q;
          addr_d      = addr_q + ADDR_STEP;
        end
        ST_RD_TURN, ST_RD_DATA: begin
          tx_d      = reg_if.i_Rd_Data[6:0];
          miso_d    = reg_if.i_Rd_Data[7];
          rd_addr_d = rd_addr_q + ADDR_STEP;
        end
        default: begin
        end
      endcase
    end else if (state_q == ST_RD_DATA) begin
      miso_d = tx_q[6];
      tx_d   = {tx_q[5:0], 1'b0};
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 7'd0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      wr_toggle_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      wr_toggle_q <= wr_toggle_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_SPI_MISO_Bit     = miso_q;
  assign o_Frame_Err        = frame_err_q;
  assign reg_if.o_Wr_Toggle = wr_toggle_q;
  assign reg_if.o_Wr_Addr   = wr_addr_q;
  assign reg_if.o_Wr_Data   = wr_data_q;
  assign reg_if.o_Rd_Addr   = rd_addr_q;

endmodule

// File: tb/tb_spi_reg_frame_decoder.sv
// Bench for spi_reg_frame_decoder: two instances (auto-increment on/off) fed the
// same frames, checked every SPI edge against a frame-level reference model.
module tb_spi_reg_frame_decoder;
  localparam int unsigned AW   = 7;
  localparam int          MASK = (1 << AW) - 1;

  logic clk_base = 1'b0;
  logic clk_en;
  logic w_SPI_Clk;
  logic i_Rst_L;
  logic i_SPI_CS_n;
  logic i_SPI_MOSI;
  logic miso_a, miso_b, err_a, err_b;
  logic [7:0] bank [128];

  always #5 clk_base = ~clk_base;
  assign w_SPI_Clk = clk_base & clk_en;

  spi_reg_frame_decoder_if #(.ADDR_WIDTH(AW)) bus_a ();
  spi_reg_frame_decoder_if #(.ADDR_WIDTH(AW)) bus_b ();
  assign bus_a.i_Rd_Data = bank[bus_a.o_Rd_Addr];
  assign bus_b.i_Rd_Data = bank[bus_b.o_Rd_Addr];

  spi_reg_frame_decoder #(.ADDR_WIDTH(AW), .AUTO_INC(1)) dut_a (
    .w_SPI_Clk      (w_SPI_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_SPI_CS_n     (i_SPI_CS_n),
    .i_SPI_MOSI     (i_SPI_MOSI),
    .o_SPI_MISO_Bit (miso_a),
    .o_Frame_Err    (err_a),
    .reg_if         (bus_a)
  );

  spi_reg_frame_decoder #(.ADDR_WIDTH(AW), .AUTO_INC(0)) dut_b (
    .w_SPI_Clk      (w_SPI_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_SPI_CS_n     (i_SPI_CS_n),
    .i_SPI_MOSI     (i_SPI_MOSI),
    .o_SPI_MISO_Bit (miso_b),
    .o_Frame_Err    (err_b),
    .reg_if         (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected outputs per instance, plus the current frame's bits.
  bit         fbits[$];
  bit         partial;
  int         inc      [2] = '{1, 0};
  int         m_tog    [2];
  int         m_wa     [2];
  int         m_wd     [2];
  int         m_ra     [2];
  int         m_err    [2];
  int         flips    [2];
  int         prev_tog [2];
  logic [15:0] cap     [2];

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    int          flips;
    int          wa_a;
    int          wa_b;
    int          wd;
    int          ra_a;
    int          ra_b;
    int          err;
    int          chk_miso;
    int          miso_a;
    int          miso_b;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act_v, input int exp_v);
    n_tests++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic get_act(input int d, output int tog, output int wa, output int wd,
                         output int ra, output int err, output int miso);
    if (d == 0) begin
      tog = int'(bus_a.o_Wr_Toggle); wa = int'(bus_a.o_Wr_Addr); wd = int'(bus_a.o_Wr_Data);
      ra = int'(bus_a.o_Rd_Addr);    err = int'(err_a);          miso = int'(miso_a);
    end else begin
      tog = int'(bus_b.o_Wr_Toggle); wa = int'(bus_b.o_Wr_Addr); wd = int'(bus_b.o_Wr_Data);
      ra = int'(bus_b.o_Rd_Addr);    err = int'(err_b);          miso = int'(miso_b);
    end
  endtask

  function automatic int byte_at(input int start);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) v = (v << 1) | int'(fbits[start + i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_tog[d] = 0; m_wa[d] = 0; m_wd[d] = 0; m_ra[d] = 0; m_err[d] = 0;
      flips[d] = 0; prev_tog[d] = 0; cap[d] = 16'd0;
    end
    partial = 1'b0;
    fbits.delete();
  endtask

  // Expected outputs after frame edge j, from the command byte and byte offsets.
  task automatic model_edge();
    int j, cmd, a0, bidx, m, k, exp_miso;
    int tog, wa, wd, ra, err, miso;
    j    = fbits.size();
    cmd  = (j >= 8) ? byte_at(0) : 0;
    a0   = cmd & MASK;
    for (int d = 0; d < 2; d++) begin
      if (j == 1 && partial) m_err[d] = 1;
      if (j % 8 == 0) begin
        bidx = j / 8 - 1;
        if (bidx == 0 && (cmd & 'h80) != 0) m_ra[d] = a0;
        if (bidx >= 1 && (cmd & 'h80) == 0) begin
          m_wa[d]  = (a0 + (bidx - 1) * inc[d]) & MASK;
          m_wd[d]  = byte_at(j - 8);
          m_tog[d] = m_tog[d] ^ 1;
        end
        if (bidx >= 1 && (cmd & 'h80) != 0) m_ra[d] = (a0 + bidx * inc[d]) & MASK;
      end
      exp_miso = 0;
      if (j >= 16 && (cmd & 'h80) != 0) begin
        m = j - 16;
        k = m / 8 + 1;
        exp_miso = (int'(bank[(a0 + (k - 1) * inc[d]) & MASK]) >> (7 - m % 8)) & 1;
      end
      get_act(d, tog, wa, wd, ra, err, miso);
      if (tog != prev_tog[d]) flips[d]++;
      prev_tog[d] = tog;
      if (j >= 16 && j <= 31) cap[d] = {cap[d][14:0], miso[0]};
      chk($sformatf("edge%0d_d%0d_miso", j, d), miso, exp_miso);
      chk($sformatf("edge%0d_d%0d_tog",  j, d), tog,  m_tog[d]);
      chk($sformatf("edge%0d_d%0d_wa",   j, d), wa,   m_wa[d]);
      chk($sformatf("edge%0d_d%0d_wd",   j, d), wd,   m_wd[d]);
      chk($sformatf("edge%0d_d%0d_ra",   j, d), ra,   m_ra[d]);
      chk($sformatf("edge%0d_d%0d_err",  j, d), err,  m_err[d]);
    end
    if (j == 1) partial = 1'b0;
  endtask

  task automatic frame_begin();
    @(negedge clk_base);
    i_SPI_CS_n = 1'b0;
    fbits.delete();
    for (int d = 0; d < 2; d++) begin
      flips[d] = 0;
      cap[d]   = 16'd0;
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk_base);
    i_SPI_MOSI = b;
    clk_en     = 1'b1;
    @(posedge clk_base);
    #1;
    fbits.push_back(b);
    model_edge();
  endtask

  task automatic frame_end();
    @(negedge clk_base);
    clk_en     = 1'b0;
    i_SPI_CS_n = 1'b1;
    partial    = (fbits.size() % 8) != 0;
    @(negedge clk_base);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic run_frame(input logic [31:0] bits, input int n);
    frame_begin();
    for (int i = 0; i < n; i++) send_bit(bits[31 - i]);
    frame_end();
  endtask

  task automatic check_zero(input string tag);
    int tog, wa, wd, ra, err, miso;
    for (int d = 0; d < 2; d++) begin
      get_act(d, tog, wa, wd, ra, err, miso);
      chk($sformatf("%s_d%0d_tog", tag, d), tog, 0);
      chk($sformatf("%s_d%0d_wa", tag, d), wa, 0);
      chk($sformatf("%s_d%0d_wd", tag, d), wd, 0);
      chk($sformatf("%s_d%0d_ra", tag, d), ra, 0);
      chk($sformatf("%s_d%0d_err", tag, d), err, 0);
      chk($sformatf("%s_d%0d_miso", tag, d), miso, 0);
    end
  endtask

  // Asynchronous reset pulse landing between SPI edges, mid-frame or idle.
  task automatic reset_pulse(input string tag);
    @(negedge clk_base);
    clk_en = 1'b0;
    #1 i_Rst_L = 1'b0;
    #1 check_zero(tag);
    #1 i_Rst_L = 1'b1;
    model_reset();
  endtask

  task automatic check_frame_end(input string tag, input int fl, input int wa_a, input int wa_b,
                                 input int wd, input int ra_a, input int ra_b, input int err);
    int tog, wa, wdv, ra, e, miso;
    get_act(0, tog, wa, wdv, ra, e, miso);
    chk({tag, "_flips_a"}, flips[0], fl);
    chk({tag, "_wa_a"}, wa, wa_a);
    chk({tag, "_wd_a"}, wdv, wd);
    chk({tag, "_ra_a"}, ra, ra_a);
    chk({tag, "_err_a"}, e, err);
    get_act(1, tog, wa, wdv, ra, e, miso);
    chk({tag, "_flips_b"}, flips[1], fl);
    chk({tag, "_wa_b"}, wa, wa_b);
    chk({tag, "_wd_b"}, wdv, wd);
    chk({tag, "_ra_b"}, ra, ra_b);
    chk({tag, "_err_b"}, e, err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, extra, cmdv, total;
    logic [7:0] cmd8;
    bit b;

    clk_en     = 1'b0;
    i_SPI_CS_n = 1'b1;
    i_SPI_MOSI = 1'b0;
    i_Rst_L    = 1'b0;
    for (int i = 0; i < 128; i++) bank[i] = 8'($urandom);
    bank[8'h12] = 8'h5A;
    bank[8'h13] = 8'hC3;
    model_reset();
    #20;
    check_zero("reset");
    i_Rst_L = 1'b1;
    #10;

    vecs[0] = '{24, 32'h05A53C00, 2, 'h06, 'h05, 'h3C, 'h00, 'h00, 0, 0, 0, 0};
    vecs[1] = '{32, 32'h92000000, 0, 'h06, 'h05, 'h3C, 'h15, 'h12, 0, 1, 'h5AC3, 'h5A5A};
    vecs[2] = '{24, 32'h7F112200, 2, 'h00, 'h7F, 'h22, 'h15, 'h12, 0, 0, 0, 0};
    vecs[3] = '{24, 32'h10AABB00, 2, 'h11, 'h10, 'hBB, 'h15, 'h12, 0, 0, 0, 0};
    vecs[4] = '{12, 32'h01A00000, 0, 'h11, 'h10, 'hBB, 'h15, 'h12, 0, 0, 0, 0};
    vecs[5] = '{16, 32'h01770000, 1, 'h01, 'h01, 'h77, 'h15, 'h12, 1, 0, 0, 0};

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].bits, vecs[v].nbits);
      check_frame_end($sformatf("vec%0d", v), vecs[v].flips, vecs[v].wa_a, vecs[v].wa_b,
                      vecs[v].wd, vecs[v].ra_a, vecs[v].ra_b, vecs[v].err);
      if (vecs[v].chk_miso != 0) begin
        chk($sformatf("vec%0d_miso_a", v), int'(cap[0]), vecs[v].miso_a);
        chk($sformatf("vec%0d_miso_b", v), int'(cap[1]), vecs[v].miso_b);
      end
    end

    // Sticky error cleared only by reset.
    reset_pulse("err_clr");

    // Reset in the middle of a read data byte; later bits form a new command.
    frame_begin();
    send_byte(8'h92);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset_pulse("rst_rd");
    send_byte(8'h30);
    send_byte(8'h44);
    frame_end();
    check_frame_end("after_rst", 1, 'h30, 'h30, 'h44, 'h00, 'h00, 0);

    frame_begin();
    send_byte(8'h20);
    send_byte(8'h99);
    frame_end();
    check_frame_end("clean_wr", 1, 'h20, 'h20, 'h99, 'h00, 'h00, 0);

    // Random frames, some cut mid-byte, with occasional idle resets.
    for (int t = 0; t < 150; t++) begin
      if (t % 25 == 24) reset_pulse($sformatf("rnd_rst%0d", t));
      nb    = int'($urandom_range(1, 5));
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      cmdv  = int'($urandom_range(0, 255));
      cmd8  = 8'(cmdv);
      total = nb * 8 + extra;
      frame_begin();
      for (int i = 0; i < total; i++) begin
        if (i < 8) b = cmd8[7 - i];
        else       b = 1'($urandom);
        send_bit(b);
      end
      frame_end();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
